// File: rtl/window3x3_line_buffer_pkg.sv
// RGB565 field layout and 3x3 window tap packing shared by the window
// producer and the network core that consumes the window buses.
package window3x3_line_buffer_pkg;

  localparam int PIX_W    = 16;
  localparam int R_W      = 5;
  localparam int G_W      = 6;
  localparam int B_W      = 5;
  localparam int B_OFF    = 0;
  localparam int G_OFF    = 5;
  localparam int R_OFF    = 11;
  localparam int WIN_DIM  = 3;
  localparam int WIN_TAPS = WIN_DIM * WIN_DIM;

  typedef logic [PIX_W-1:0] pixel_t;

  // Tap i = row*3 + col; row 0 is the oldest line, col 0 the oldest column.
  function automatic int tap_index(input int row, input int col);
    return row * WIN_DIM + col;
  endfunction

  function automatic logic [R_W-1:0] red_of(input pixel_t p);
    return p[R_OFF +: R_W];
  endfunction

  function automatic logic [G_W-1:0] green_of(input pixel_t p);
    return p[G_OFF +: G_W];
  endfunction

  function automatic logic [B_W-1:0] blue_of(input pixel_t p);
    return p[B_OFF +: B_W];
  endfunction

endpackage

// File: rtl/window3x3_line_buffer_line_buffer.sv
// One image line of storage: asynchronous read, synchronous write on the
// same address, so a read in the write cycle returns the previous contents.
module window3x3_line_buffer_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 16,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Contents are never reset; stale data is masked by the row counter.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/window3x3_line_buffer.sv
// Raster RGB565 stream to packed 3x3 window buses. Two line buffers supply
// the two older rows; a 3x3 register array slides one column per accepted
// pixel, and a window is emitted for every interior centre pixel.
module window3x3_line_buffer
  import window3x3_line_buffer_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int XW         = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pix_valid,
  input  logic [PIX_W-1:0]          pix_data,
  input  logic                      sof,
  output logic                      window_valid,
  output logic [WIN_TAPS*R_W-1:0]   r_channel,
  output logic [WIN_TAPS*G_W-1:0]   g_channel,
  output logic [WIN_TAPS*B_W-1:0]   b_channel,
  output logic [XW-1:0]             win_x,
  output logic [XW-1:0]             win_y,
  output logic                      frame_done
);

  localparam int LB_AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

  logic [XW-1:0]    x;
  logic [XW-1:0]    y;
  logic             synced;
  logic             accept;
  logic             emit;
  logic             last_col;
  logic             last_row;
  logic [XW-1:0]    cur_x;
  logic [XW-1:0]    cur_y;
  logic [LB_AW-1:0] lb_addr;
  pixel_t           top_pix;
  pixel_t           mid_pix;
  pixel_t           win_p1 [WIN_DIM][WIN_DIM];
  pixel_t           win_nx [WIN_DIM][WIN_DIM];
  logic [WIN_TAPS*R_W-1:0] r_nx;
  logic [WIN_TAPS*G_W-1:0] g_nx;
  logic [WIN_TAPS*B_W-1:0] b_nx;

  // Input stage: acceptance and the effective position (sof forces 0,0).
  always_comb begin
    accept   = pix_valid & (synced | sof);
    cur_x    = sof ? '0 : x;
    cur_y    = sof ? '0 : y;
    last_col = (cur_x == XW'(IMG_WIDTH - 1));
    last_row = (cur_y == XW'(IMG_HEIGHT - 1));
    emit     = accept && (cur_x >= XW'(2)) && (cur_y >= XW'(2));
    lb_addr  = cur_x[LB_AW-1:0];
  end

  // lb0 holds line y-1, lb1 holds line y-2; each write pushes a line down.
  window3x3_line_buffer_line_buffer #(
    .DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(LB_AW)
  ) lb0 (
    .clk(clk), .we(accept), .addr(lb_addr), .wdata(pix_data), .rdata(mid_pix)
  );

  window3x3_line_buffer_line_buffer #(
    .DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(LB_AW)
  ) lb1 (
    .clk(clk), .we(accept), .addr(lb_addr), .wdata(mid_pix), .rdata(top_pix)
  );

  // Window after this pixel: columns shift left, new column enters at col 2.
  always_comb begin
    win_nx = win_p1;
    for (int row = 0; row < WIN_DIM; row++) begin
      for (int col = 0; col < WIN_DIM - 1; col++) begin
        win_nx[row][col] = win_p1[row][col+1];
      end
    end
    win_nx[0][WIN_DIM-1] = top_pix;
    win_nx[1][WIN_DIM-1] = mid_pix;
    win_nx[2][WIN_DIM-1] = pix_data;
  end

  // Pack the next window into per-channel tap buses.
  always_comb begin
    r_nx = '0;
    g_nx = '0;
    b_nx = '0;
    for (int row = 0; row < WIN_DIM; row++) begin
      for (int col = 0; col < WIN_DIM; col++) begin
        r_nx[tap_index(row, col)*R_W +: R_W] = red_of(win_nx[row][col]);
        g_nx[tap_index(row, col)*G_W +: G_W] = green_of(win_nx[row][col]);
        b_nx[tap_index(row, col)*B_W +: B_W] = blue_of(win_nx[row][col]);
      end
    end
  end

  // Raster counters, sync flag and the one-cycle status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x            <= '0;
      y            <= '0;
      synced       <= 1'b0;
      frame_done   <= 1'b0;
      window_valid <= 1'b0;
      win_x        <= '0;
      win_y        <= '0;
    end else begin
      frame_done   <= 1'b0;
      window_valid <= emit;
      if (accept) begin
        synced <= 1'b1;
        if (last_col) begin
          x <= '0;
          if (last_row) begin
            y          <= '0;
            synced     <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            y <= cur_y + XW'(1);
          end
        end else begin
          x <= cur_x + XW'(1);
          y <= cur_y;
        end
      end
      if (emit) begin
        win_x <= cur_x - XW'(1);
        win_y <= cur_y - XW'(1);
      end
    end
  end

  // Window stage: slide on every accepted pixel; buses load only on emit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int row = 0; row < WIN_DIM; row++) begin
        for (int col = 0; col < WIN_DIM; col++) begin
          win_p1[row][col] <= '0;
        end
      end
      r_channel <= '0;
      g_channel <= '0;
      b_channel <= '0;
    end else begin
      if (accept) win_p1 <= win_nx;
      if (emit) begin
        r_channel <= r_nx;
        g_channel <= g_nx;
        b_channel <= b_nx;
      end
    end
  end

endmodule
